// File: rtl/iic_eeprom_responder.sv
// 24Cxx-style IIC EEPROM slave: oversampled SCL/SDA, 2-byte word address, page write, sequential read.
// Optional write-cycle (ack-polling) emulation under `IIC_EEPROM_TWR_EN; bus-paced, no backpressure beyond ACK/NACK.
`timescale 1ns/1ps
module iic_eeprom_responder #(
    parameter logic [2:0] DEV_SEL    = 3'b000,
    parameter int         MEM_AW     = 8,
    parameter int         PAGE_BYTES = 32,
    parameter int         TWR_CYCLES = 5000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_iic_scl,
    inout  wire               io_iic_sda,
    input  logic              i_wp,
    output logic              o_busy,
    output logic              o_access_valid,
    output logic              o_access_we,
    output logic [MEM_AW-1:0] o_access_addr,
    output logic [7:0]        o_access_data
);
    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, ADDR_HI, ACK_AH, ADDR_LO, ACK_AL, WRITE, ACK_WR, READ, MACK
    } state_t;

    localparam logic [MEM_AW-1:0] PMASK = MEM_AW'(PAGE_BYTES - 1);

    state_t            state, state_nxt;
    logic [2:0]        scl_p, sda_p;
    logic              sda_oe, oe_nxt;
    logic [3:0]        bit_cnt;
    logic [7:0]        rx_sh, tx_sh;
    logic [MEM_AW-1:0] addr, addr_sh;
    logic              busy;
    logic [7:0]        mem [0:(1<<MEM_AW)-1] = '{default: 8'hFF};

    logic scl, scl_h, sda, sda_h;
    logic start_c, stop_c, rise, fall, byte_done, dev_hit;
    logic rx_shift, tx_shift, cnt_clr, load, store, addr_load, addr_inc, stop_evt;

    assign io_iic_sda = sda_oe ? 1'b0 : 1'bz;

    assign scl   = scl_p[1];
    assign scl_h = scl_p[2];
    assign sda   = sda_p[1];
    assign sda_h = sda_p[2];

    assign start_c   = scl && scl_h && sda_h && !sda;
    assign stop_c    = scl && scl_h && !sda_h && sda;
    assign rise      = scl && !scl_h;
    assign fall      = !scl && scl_h;
    assign byte_done = (bit_cnt == 4'd8);
    assign dev_hit   = (rx_sh[7:1] == {4'b1010, DEV_SEL}) && !busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_p <= 3'b111;
            sda_p <= 3'b111;
        end else begin
            scl_p <= {scl_p[1:0], i_iic_scl};
            sda_p <= {sda_p[1:0], io_iic_sda};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
        end else begin
            state  <= state_nxt;
            sda_oe <= oe_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        oe_nxt    = sda_oe;
        rx_shift  = 1'b0;
        tx_shift  = 1'b0;
        cnt_clr   = 1'b0;
        load      = 1'b0;
        store     = 1'b0;
        addr_load = 1'b0;
        addr_inc  = 1'b0;
        stop_evt  = 1'b0;
        if (start_c) begin
            state_nxt = DEVADDR;
            oe_nxt    = 1'b0;
            cnt_clr   = 1'b0 | 1'b1;
        end else if (stop_c) begin
            state_nxt = IDLE;
            oe_nxt    = 1'b0;
            cnt_clr   = 1'b1;
            stop_evt  = 1'b1;
        end else begin
            case (state)
                DEVADDR, ADDR_HI, ADDR_LO, WRITE: begin
                    if (rise && !byte_done) begin
                        rx_shift = 1'b1;
                    end else if (fall && byte_done) begin
                        cnt_clr = 1'b1;
                        case (state)
                            DEVADDR: begin
                                if (dev_hit) begin
                                    state_nxt = ACK_DEV;
                                    oe_nxt    = 1'b1;
                                end else begin
                                    state_nxt = IDLE;
                                end
                            end
                            ADDR_HI: begin
                                state_nxt = ACK_AH;
                                oe_nxt    = 1'b1;
                            end
                            ADDR_LO: begin
                                state_nxt = ACK_AL;
                                oe_nxt    = 1'b1;
                                addr_load = 1'b1;
                            end
                            default: begin
                                state_nxt = ACK_WR;
                                if (!i_wp) begin
                                    oe_nxt = 1'b1;
                                    store  = 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ACK_DEV: begin
                    // Prefetch the first read byte while the master clocks our ACK
                    if (rise && rx_sh[0]) load = 1'b1;
                    if (fall) begin
                        cnt_clr = 1'b1;
                        if (rx_sh[0]) begin
                            state_nxt = READ;
                            oe_nxt    = ~tx_sh[7];
                        end else begin
                            state_nxt = ADDR_HI;
                            oe_nxt    = 1'b0;
                        end
                    end
                end
                ACK_AH, ACK_AL, ACK_WR: begin
                    if (fall) begin
                        state_nxt = (state == ACK_AH) ? ADDR_LO : WRITE;
                        oe_nxt    = 1'b0;
                        cnt_clr   = 1'b1;
                    end
                end
                READ: begin
                    if (fall) begin
                        if (bit_cnt == 4'd7) begin
                            state_nxt = MACK;
                            oe_nxt    = 1'b0;
                            addr_inc  = 1'b1;
                        end else begin
                            tx_shift = 1'b1;
                            oe_nxt   = ~tx_sh[6];
                        end
                    end
                end
                MACK: begin
                    // Master ACK lands in rx_sh[0]; only an ACK fetches the next byte
                    if (rise) begin
                        rx_shift = 1'b1;
                        load     = !sda;
                    end
                    if (fall) begin
                        cnt_clr = 1'b1;
                        if (!rx_sh[0]) begin
                            state_nxt = READ;
                            oe_nxt    = ~tx_sh[7];
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (store) mem[addr] <= rx_sh;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt        <= 4'd0;
            rx_sh          <= 8'd0;
            tx_sh          <= 8'hFF;
            addr           <= '0;
            addr_sh        <= '0;
            o_access_valid <= 1'b0;
            o_access_we    <= 1'b0;
            o_access_addr  <= '0;
            o_access_data  <= 8'd0;
        end else begin
            o_access_valid <= 1'b0;
            if (cnt_clr)                  bit_cnt <= 4'd0;
            else if (rx_shift || tx_shift) bit_cnt <= bit_cnt + 4'd1;
            if (rx_shift) rx_sh <= {rx_sh[6:0], sda};
            if (rx_shift && (state == ADDR_HI || state == ADDR_LO))
                addr_sh <= {addr_sh[MEM_AW-2:0], sda};
            if (load) begin
                tx_sh          <= mem[addr];
                o_access_valid <= 1'b1;
                o_access_we    <= 1'b0;
                o_access_addr  <= addr;
                o_access_data  <= mem[addr];
            end else if (tx_shift) begin
                tx_sh <= {tx_sh[6:0], 1'b1};
            end
            if (store) begin
                o_access_valid <= 1'b1;
                o_access_we    <= 1'b1;
                o_access_addr  <= addr;
                o_access_data  <= rx_sh;
                // Page write wraps inside the page; upper address bits stay put
                addr           <= (addr & ~PMASK) | ((addr + 1'b1) & PMASK);
            end else if (addr_load) begin
                addr <= addr_sh;
            end else if (addr_inc) begin
                addr <= addr + 1'b1;
            end
        end
    end

`ifdef IIC_EEPROM_TWR_EN
    logic [31:0] twr_cnt;
    logic        wrote;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            twr_cnt <= 32'd0;
            wrote   <= 1'b0;
        end else begin
            if (stop_evt && wrote) begin
                twr_cnt <= 32'(TWR_CYCLES);
                wrote   <= 1'b0;
            end else begin
                if (twr_cnt != 32'd0) twr_cnt <= twr_cnt - 32'd1;
                if (store)            wrote   <= 1'b1;
            end
        end
    end

    assign busy = (twr_cnt != 32'd0);
`else
    assign busy = 1'b0;
`endif

    assign o_busy = busy;
endmodule

// File: tb/tb_iic_eeprom_responder.sv
// Directed bench for iic_eeprom_responder: table of bus operations plus hand sequences for corner cases.
`timescale 1ns/1ps
module tb_iic_eeprom_responder;
    localparam int TWR = 100;

    typedef enum logic [2:0] {OP_S, OP_P, OP_W, OP_RA, OP_RN} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       wp = 1'b0;
    wire        sda_bus;
    logic       busy, acc_valid, acc_we;
    logic [7:0] acc_addr, acc_data;

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = m_sda ? 1'bz : 1'b0;

    iic_eeprom_responder #(
        .DEV_SEL(3'b000), .MEM_AW(8), .PAGE_BYTES(32), .TWR_CYCLES(TWR)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_iic_scl(scl), .io_iic_sda(sda_bus), .i_wp(wp),
        .o_busy(busy), .o_access_valid(acc_valid), .o_access_we(acc_we),
        .o_access_addr(acc_addr), .o_access_data(acc_data)
    );

    int          checks = 0;
    int          errors = 0;
    int          q = 5;
    vec_t        vt[$];
    logic [16:0] slog[$];
    logic [16:0] exp_sl [0:14];
    int          busy_cyc = 0;
    int          dut_low = 0;

    always @(negedge clk) begin
        if (acc_valid) slog.push_back({acc_we, acc_addr, acc_data});
        if (busy) busy_cyc++;
        if (sda_bus === 1'b0 && m_sda) dut_low++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b;
        wait_clk(q);
        scl = 1'b1;
        wait_clk(q);
        s = sda_bus;
        wait_clk(q);
        scl = 1'b0;
        wait_clk(q);
    endtask

    task automatic do_start();
        m_sda = 1'b1;
        wait_clk(q);
        scl = 1'b1;
        wait_clk(q);
        m_sda = 1'b0;
        wait_clk(q);
        scl = 1'b0;
        wait_clk(q);
    endtask

    task automatic do_stop();
        m_sda = 1'b0;
        wait_clk(q);
        scl = 1'b1;
        wait_clk(q);
        m_sda = 1'b1;
        wait_clk(2 * q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    function automatic void add(input op_t o, input logic [7:0] d, input logic [7:0] e);
        vt.push_back('{op: o, dat: d, exp: e});
    endfunction

    function automatic void add_wr(input logic [7:0] lo, input logic [7:0] d);
        add(OP_S, 0, 0); add(OP_W, 8'hA0, 1); add(OP_W, 8'h00, 1); add(OP_W, lo, 1);
        add(OP_W, d, 1); add(OP_P, 0, 0);
    endfunction

    initial begin
        logic       ack;
        logic [7:0] d;
        logic       s;
        int         n0, b0, lo0, nw;

        // Preloads, page write/read table (tests 1, 2, 3)
        add_wr(8'h12, 8'h3C);
        add_wr(8'h20, 8'h5A);
        add_wr(8'h40, 8'h66);
        add(OP_S, 0, 0); add(OP_W, 8'hA0, 1); add(OP_W, 8'h00, 1); add(OP_W, 8'h10, 1);
        add(OP_W, 8'h55, 1); add(OP_W, 8'hAA, 1); add(OP_P, 0, 0);
        add(OP_S, 0, 0); add(OP_W, 8'hA0, 1); add(OP_W, 8'h00, 1); add(OP_W, 8'h10, 1);
        add(OP_S, 0, 0); add(OP_W, 8'hA1, 1); add(OP_RA, 0, 8'h55); add(OP_RN, 0, 8'hAA); add(OP_P, 0, 0);
        add(OP_S, 0, 0); add(OP_W, 8'hA1, 1); add(OP_RN, 0, 8'h3C); add(OP_P, 0, 0);
        add(OP_S, 0, 0); add(OP_W, 8'hA0, 1); add(OP_W, 8'h00, 1); add(OP_W, 8'h1F, 1);
        add(OP_W, 8'h01, 1); add(OP_W, 8'h02, 1); add(OP_W, 8'h03, 1); add(OP_P, 0, 0);
        add(OP_S, 0, 0); add(OP_W, 8'hA0, 1); add(OP_W, 8'h00, 1); add(OP_W, 8'h1F, 1);
        add(OP_S, 0, 0); add(OP_W, 8'hA1, 1); add(OP_RA, 0, 8'h01); add(OP_RN, 0, 8'h5A); add(OP_P, 0, 0);
        add(OP_S, 0, 0); add(OP_W, 8'hA0, 1); add(OP_W, 8'h00, 1); add(OP_W, 8'h00, 1);
        add(OP_S, 0, 0); add(OP_W, 8'hA1, 1); add(OP_RA, 0, 8'h02); add(OP_RN, 0, 8'h03); add(OP_P, 0, 0);

        exp_sl = '{17'h1123C, 17'h1205A, 17'h14066, 17'h11055, 17'h111AA,
                   17'h01055, 17'h011AA, 17'h0123C, 17'h11F01, 17'h10002,
                   17'h10103, 17'h01F01, 17'h0205A, 17'h00002, 17'h00103};

        rst = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        check("rst_busy", busy, 0);
        check("rst_valid", acc_valid, 0);
        check("rst_we", acc_we, 0);
        check("rst_addr", acc_addr, 0);
        check("rst_data", acc_data, 0);
        check("rst_sda", sda_bus, 1);

        for (int i = 0; i < vt.size(); i++) begin
            case (vt[i].op)
                OP_S: do_start();
                OP_P: do_stop();
                OP_W: begin
                    send_byte(vt[i].dat, ack);
                    check($sformatf("ack[%0d]", i), ack, vt[i].exp[0]);
                end
                default: begin
                    recv_byte(vt[i].op == OP_RN, d);
                    check($sformatf("rd[%0d]", i), d, vt[i].exp);
                end
            endcase
        end

        check("strobe_count", slog.size(), 15);
        for (int i = 0; i < 15; i++)
            if (i < slog.size()) check($sformatf("strobe[%0d]", i), slog[i], exp_sl[i]);

        // Wrong chip select: no ACK, DUT never pulls SDA, later bytes ignored until START
        n0 = slog.size();
        lo0 = dut_low;
        do_start();
        send_byte(8'hA2, ack);
        check("a2_nack", ack, 0);
        send_byte(8'h00, ack);
        check("idle_nack", ack, 0);
        check("a2_no_drive", dut_low - lo0, 0);
        do_stop();
        check("a2_no_strobe", slog.size(), n0);

        // Write protect: control bytes ACKed, data NACKed and not stored
        wp = 1'b1;
        do_start();
        send_byte(8'hA0, ack); check("wp_dev_ack", ack, 1);
        send_byte(8'h00, ack); check("wp_ah_ack", ack, 1);
        send_byte(8'h10, ack); check("wp_al_ack", ack, 1);
        send_byte(8'h77, ack); check("wp_data_nack", ack, 0);
        do_stop();
        wp = 1'b0;
        check("wp_no_strobe", slog.size(), n0);
        do_start();
        send_byte(8'hA0, ack); send_byte(8'h00, ack); send_byte(8'h10, ack);
        do_start();
        send_byte(8'hA1, ack);
        recv_byte(1'b1, d);
        do_stop();
        check("wp_mem_kept", d, 8'h55);
        if (slog.size() > n0) check("wp_read_strobe", slog[n0], 17'h01055);
        else check("wp_read_strobe", slog.size(), n0 + 1);

        // STOP after 4 data bits: partial byte discarded, bus released, next START works
        n0 = slog.size();
        do_start();
        send_byte(8'hA0, ack); send_byte(8'h00, ack); send_byte(8'h40, ack);
        check("abort_setup_ack", ack, 1);
        clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
        do_stop();
        check("abort_no_strobe", slog.size(), n0);
        check("abort_sda_rel", sda_bus, 1);
        do_start();
        send_byte(8'hA0, ack); check("after_abort_ack", ack, 1);
        send_byte(8'h00, ack); send_byte(8'h40, ack);
        do_start();
        send_byte(8'hA1, ack);
        recv_byte(1'b1, d);
        do_stop();
        check("abort_mem_kept", d, 8'h66);

`ifdef IIC_EEPROM_TWR_EN
        // Write cycle emulation: busy for TWR cycles, device NACKs while busy
        wait_clk(2 * TWR);
        q = 2;
        do_start();
        send_byte(8'hA0, ack); send_byte(8'h00, ack); send_byte(8'h50, ack); send_byte(8'h11, ack);
        b0 = busy_cyc;
        do_stop();
        check("twr_busy_set", busy, 1);
        do_start();
        send_byte(8'hA0, ack);
        check("twr_poll_nack", ack, 0);
        do_stop();
        nw = 0;
        while (busy && nw < 1000) begin
            wait_clk(1);
            nw++;
        end
        check("twr_busy_fall", busy, 0);
        check("twr_busy_len", busy_cyc - b0, TWR);
        do_start();
        send_byte(8'hA0, ack);
        check("twr_after_ack", ack, 1);
        do_stop();
        q = 5;
`else
        b0 = 0;
        check("busy_never", busy_cyc - b0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
